// File: rtl/uart_rx_hex_buffer_pkg.sv
// Shared definitions for the UART RX display-history stage: FSM encoding,
// digit word field positions and history sizing.
package uart_rx_hex_buffer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    localparam int EN_BIT     = 5;
    localparam int HEX_MSB    = 4;
    localparam int HEX_LSB    = 1;
    localparam int DP_BIT     = 0;

    localparam int HIST_BYTES = 4;
    localparam int FILL_W     = 3;

endpackage

// File: rtl/uart_rx_hex_buffer_byte_history_reg.sv
// Four-deep byte shift history (index 0 = newest) with a synchronous clear
// and a fill counter that saturates at the history depth.
module byte_history_reg
    import uart_rx_hex_buffer_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           load,
    input  logic                           clear,
    input  logic [7:0]                     din,
    output logic [HIST_BYTES-1:0][7:0]     hist,
    output logic [FILL_W-1:0]              fill
);

    logic [HIST_BYTES-1:0][7:0] hist_q, hist_d;
    logic [FILL_W-1:0]          fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (load) begin
            // Oldest byte falls off the top; the new byte enters at index 0.
            hist_d = {hist_q[HIST_BYTES-2:0], din};
            if (fill_q != FILL_W'(HIST_BYTES)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/uart_rx_hex_buffer.sv
// Pops bytes from the UART RX FIFO into a four-byte history and packs them as
// eight {en, hex, dp} digit words for the seven-segment driver.
module uart_rx_hex_buffer
    import uart_rx_hex_buffer_pkg::*;
#(
    parameter bit DP_NEWEST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rd_uart,
    input  logic              freeze,
    input  logic              clear,
    output logic [FILL_W-1:0] fill,
    output logic [5:0]        I0,
    output logic [5:0]        I1,
    output logic [5:0]        I2,
    output logic [5:0]        I3,
    output logic [5:0]        I4,
    output logic [5:0]        I5,
    output logic [5:0]        I6,
    output logic [5:0]        I7
);

    state_e                     state_q, state_d;
    logic                       pop;
    logic [HIST_BYTES-1:0][7:0] hist;
    logic [5:0]                 digit [2*HIST_BYTES];

    // SETTLE gives the FIFO a cycle to refresh rx_empty and its head byte.
    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!freeze && !rx_empty) begin
                        pop     = 1'b1;
                        state_d = SETTLE;
                    end
                end
                SETTLE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign rd_uart = pop;

    byte_history_reg u_hist (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pop),
        .clear   (clear),
        .din     (rx_data),
        .hist    (hist),
        .fill    (fill)
    );

    always_comb begin
        for (int k = 0; k < HIST_BYTES; k++) begin
            digit[2*k]                    = '0;
            digit[2*k+1]                  = '0;
            digit[2*k][EN_BIT]            = (FILL_W'(k) < fill);
            digit[2*k+1][EN_BIT]          = (FILL_W'(k) < fill);
            digit[2*k][HEX_MSB:HEX_LSB]   = hist[k][3:0];
            digit[2*k+1][HEX_MSB:HEX_LSB] = hist[k][7:4];
        end
        digit[0][DP_BIT] = DP_NEWEST && (fill != '0);
    end

    assign I0 = digit[0];
    assign I1 = digit[1];
    assign I2 = digit[2];
    assign I3 = digit[3];
    assign I4 = digit[4];
    assign I5 = digit[5];
    assign I6 = digit[6];
    assign I7 = digit[7];

endmodule

// File: tb/tb_uart_rx_hex_buffer.sv
// Self-checking bench for uart_rx_hex_buffer: two instances (DP_NEWEST=1 and
// DP_NEWEST=0) share stimulus and are compared against a queue-based model.
module tb_uart_rx_hex_buffer;

    logic       clk;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       freeze;
    logic       clear;

    logic       a_rd, b_rd;
    logic [2:0] a_fill, b_fill;
    logic [5:0] a_I0, a_I1, a_I2, a_I3, a_I4, a_I5, a_I6, a_I7;
    logic [5:0] b_I0, b_I1, b_I2, b_I3, b_I4, b_I5, b_I6, b_I7;
    logic [5:0] a_i [8];
    logic [5:0] b_i [8];

    int n_checks;
    int n_fail;

    // model: history bytes, newest first, and whether the previous edge popped
    logic [7:0] hq[$];
    logic       last_pop;
    logic       exp_pop;

    typedef struct {
        logic       clr;
        logic       frz;
        logic       emp;
        logic [7:0] data;
        logic       exp_rd;
        logic [2:0] exp_fill;
        logic [5:0] exp_i0;
    } vec_t;

    vec_t vecs [6];

    uart_rx_hex_buffer #(.DP_NEWEST(1'b1)) u_dut_dp (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_empty(rx_empty),
        .rd_uart(a_rd), .freeze(freeze), .clear(clear), .fill(a_fill),
        .I0(a_I0), .I1(a_I1), .I2(a_I2), .I3(a_I3),
        .I4(a_I4), .I5(a_I5), .I6(a_I6), .I7(a_I7)
    );

    uart_rx_hex_buffer #(.DP_NEWEST(1'b0)) u_dut_nodp (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_empty(rx_empty),
        .rd_uart(b_rd), .freeze(freeze), .clear(clear), .fill(b_fill),
        .I0(b_I0), .I1(b_I1), .I2(b_I2), .I3(b_I3),
        .I4(b_I4), .I5(b_I5), .I6(b_I6), .I7(b_I7)
    );

    assign a_i[0] = a_I0; assign a_i[1] = a_I1; assign a_i[2] = a_I2; assign a_i[3] = a_I3;
    assign a_i[4] = a_I4; assign a_i[5] = a_I5; assign a_i[6] = a_I6; assign a_i[7] = a_I7;
    assign b_i[0] = b_I0; assign b_i[1] = b_I1; assign b_i[2] = b_I2; assign b_i[3] = b_I3;
    assign b_i[4] = b_I4; assign b_i[5] = b_I5; assign b_i[6] = b_I6; assign b_i[7] = b_I7;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected digit word d (0..7) derived from the held bytes.
    function automatic logic [5:0] model_digit(input int d, input bit dp_newest);
        int         k;
        logic [7:0] b;
        logic       en;
        logic [3:0] nib;
        logic       dp;
        k   = d / 2;
        en  = (k < hq.size());
        b   = en ? hq[k] : 8'h00;
        nib = (d % 2 == 0) ? b[3:0] : b[7:4];
        dp  = (d == 0) && dp_newest && (hq.size() != 0);
        return {en, nib, dp};
    endfunction

    task automatic check_regs();
        check("fill", 32'(a_fill), 32'(hq.size()));
        check("fill_nodp", 32'(b_fill), 32'(hq.size()));
        for (int d = 0; d < 8; d++) begin
            check($sformatf("I%0d", d), 32'(a_i[d]), 32'(model_digit(d, 1'b1)));
            check($sformatf("I%0d_nodp", d), 32'(b_i[d]), 32'(model_digit(d, 1'b0)));
        end
    endtask

    function automatic void model_reset();
        hq.delete();
        last_pop = 1'b0;
    endfunction

    // driver: one full clock cycle with checks before the edge, model after
    task automatic cycle(input logic clr, input logic frz, input logic emp, input logic [7:0] data);
        @(negedge clk);
        clear    = clr;
        freeze   = frz;
        rx_empty = emp;
        rx_data  = data;
        #1;
        exp_pop = !clr && !frz && !emp && !last_pop;
        check("rd_uart", 32'(a_rd), 32'(exp_pop));
        check("rd_uart_nodp", 32'(b_rd), 32'(exp_pop));
        check_regs();
        @(posedge clk);
        if (clr) begin
            hq.delete();
            last_pop = 1'b0;
        end else if (exp_pop) begin
            hq.push_front(data);
            if (hq.size() > 4) void'(hq.pop_back());
            last_pop = 1'b1;
        end else begin
            last_pop = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] src [5];
        int         idx;
        int         pops;
        int         budget;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        rx_data  = 8'h00;
        rx_empty = 1'b1;
        freeze   = 1'b0;
        clear    = 1'b0;
        model_reset();

        //              clr   frz   emp   data   rd    fill  I0
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 6'b0_0000_0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd0, 6'b0_0000_0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 6'b1_0101_1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 3'd1, 6'b1_0101_1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 3'd0, 6'b0_0000_0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 6'b1_0111_1};

        repeat (3) @(negedge clk);
        #1;
        check("reset_rd", 32'(a_rd), 32'd0);
        check_regs();
        @(negedge clk);
        reset_n = 1'b1;

        // idle with empty FIFO
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 8'h3C);

        // directed table: single byte, then clear racing a non-empty FIFO
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            clear    = vecs[v].clr;
            freeze   = vecs[v].frz;
            rx_empty = vecs[v].emp;
            rx_data  = vecs[v].data;
            #1;
            check($sformatf("vec%0d_rd", v), 32'(a_rd), 32'(vecs[v].exp_rd));
            check($sformatf("vec%0d_fill", v), 32'(a_fill), 32'(vecs[v].exp_fill));
            check($sformatf("vec%0d_I0", v), 32'(a_I0), 32'(vecs[v].exp_i0));
            check($sformatf("vec%0d_I0_nodp", v), 32'(b_I0), 32'({vecs[v].exp_i0[5:1], 1'b0}));
            if (v == 2) begin
                check("single_I1", 32'(a_I1), 32'(6'b1_1010_0));
                check("single_I2", 32'(a_I2), 32'd0);
            end
            @(posedge clk);
            if (vecs[v].clr) begin
                hq.delete();
                last_pop = 1'b0;
            end else if (vecs[v].exp_rd) begin
                hq.push_front(vecs[v].data);
                last_pop = 1'b1;
            end else begin
                last_pop = 1'b0;
            end
        end

        // five-byte burst with the FIFO never empty
        cycle(1'b1, 1'b0, 1'b1, 8'h00);
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44; src[4] = 8'h55;
        idx    = 0;
        pops   = 0;
        budget = 0;
        while (idx < 5 && budget < 20) begin
            cycle(1'b0, 1'b0, 1'b0, src[idx]);
            if (exp_pop) begin
                idx++;
                pops++;
            end
            budget++;
        end
        check("burst_pops", 32'(pops), 32'd5);
        check("burst_cycles", 32'(budget), 32'd9);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check("burst_I0", 32'(a_I0), 32'(6'b1_0101_1));
        check("burst_I7", 32'(a_I7), 32'(6'b1_0010_0));
        check("burst_fill", 32'(a_fill), 32'd4);

        // freeze holds the display with data waiting
        repeat (10) cycle(1'b0, 1'b1, 1'b0, 8'h9E);
        @(negedge clk);
        freeze = 1'b0;
        #1;
        check("freeze_release_rd", 32'(a_rd), 32'd1);
        @(posedge clk);
        hq.push_front(8'h9E);
        void'(hq.pop_back());
        last_pop = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 8'h00);

        // async reset while in SETTLE
        cycle(1'b0, 1'b0, 1'b0, 8'hC3);
        @(negedge clk);
        rx_empty = 1'b1;
        reset_n  = 1'b0;
        #1;
        model_reset();
        check("rst_settle_rd", 32'(a_rd), 32'd0);
        check_regs();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'h5A);
        check("rst_release_pop", 32'(exp_pop), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 0), 8'($urandom));
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
